// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 32-bit x^32+x^22+x^2+x+1 pattern generator.
// Optional bit-error statistics are built only when PRBS_CHK_BITCNT_EN is defined.
module prbs_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             clear,
  output logic [1:0]       state,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] word_err_cnt
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [CNT_W-1:0] bit_err_cnt
`endif
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LW = $clog2(LOSS_CNT + 1);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [31:0]      exp_q, exp_nx;
  logic [MW-1:0]    match_cnt, match_nx, match_inc;
  logic [LW-1:0]    miss_cnt, miss_nx;
  logic [1:0]       state_nx;
  logic             mism;
  logic [CNT_W-1:0] wcnt_nx;

  function automatic logic [31:0] lfsr_next(input logic [31:0] w);
    return {w[30:0], w[31] ^ w[21] ^ w[1] ^ w[0]};
  endfunction

  always_comb begin
    exp_nx    = exp_q;
    match_nx  = match_cnt;
    miss_nx   = miss_cnt;
    state_nx  = state;
    mism      = 1'b0;
    match_inc = match_cnt + MW'(1);
    if (in_valid) begin
      case (state)
        S_SEARCH: begin
          if (in_data != '0) begin
            exp_nx   = lfsr_next(in_data);
            match_nx = '0;
            state_nx = S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (in_data == exp_q) begin
            exp_nx   = lfsr_next(exp_q);
            match_nx = match_inc;
            if (match_inc == MW'(LOCK_CNT)) begin
              state_nx = S_LOCKED;
              miss_nx  = '0;
            end
          end else if (in_data != '0) begin
            exp_nx   = lfsr_next(in_data);
            match_nx = '0;
          end else begin
            state_nx = S_SEARCH;
          end
        end
        S_LOCKED: begin
          // Flywheel: once locked the reference is never reseeded from the input.
          exp_nx = lfsr_next(exp_q);
          if (in_data == exp_q) begin
            miss_nx = '0;
          end else begin
            mism    = 1'b1;
            miss_nx = miss_cnt + LW'(1);
            if (miss_nx == LW'(LOSS_CNT))
              state_nx = S_SEARCH;
          end
        end
        default: state_nx = S_SEARCH;
      endcase
    end
  end

  always_comb begin
    wcnt_nx = word_err_cnt;
    if (clear)
      wcnt_nx = '0;
    else if (mism && (word_err_cnt != '1))
      wcnt_nx = word_err_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_SEARCH;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      exp_q        <= '0;
      match_cnt    <= '0;
      miss_cnt     <= '0;
      word_err_cnt <= '0;
    end else begin
      state        <= state_nx;
      locked       <= (state_nx == S_LOCKED);
      err_pulse    <= mism;
      exp_q        <= exp_nx;
      match_cnt    <= match_nx;
      miss_cnt     <= miss_nx;
      word_err_cnt <= wcnt_nx;
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  // Sum is one bit wider than both operands so the clamp sees any overflow.
  localparam int unsigned SW = ((CNT_W > 6) ? CNT_W : 6) + 1;

  logic [31:0]      diff;
  logic [5:0]       pop;
  logic [SW-1:0]    bsum;
  logic [CNT_W-1:0] bcnt_nx;

  always_comb begin
    diff = in_data ^ exp_q;
    pop  = '0;
    for (int unsigned i = 0; i < 32; i++)
      pop = pop + 6'(diff[i]);
    bsum    = SW'(bit_err_cnt) + SW'(pop);
    bcnt_nx = bit_err_cnt;
    if (clear)
      bcnt_nx = '0;
    else if (mism)
      bcnt_nx = (bsum > SW'({CNT_W{1'b1}})) ? '1 : CNT_W'(bsum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bit_err_cnt <= '0;
    else
      bit_err_cnt <= bcnt_nx;
  end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, errors, loss/relock, reseed, saturation, clear, async reset.
module tb_prbs_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        va = 1'b0, ca = 1'b0, vb = 1'b0, cb = 1'b0;
  logic [31:0] da = '0, db = '0;
  logic [1:0]  st_a, st_b;
  logic        lk_a, lk_b, ep_a, ep_b;
  logic [15:0] wc_a;
  logic [3:0]  wc_b;
`ifdef PRBS_CHK_BITCNT_EN
  logic [15:0] bc_a;
  logic [3:0]  bc_b;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  prbs_checker #(.LOCK_CNT(4), .LOSS_CNT(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_data(da), .clear(ca),
    .state(st_a), .locked(lk_a), .err_pulse(ep_a), .word_err_cnt(wc_a)
`ifdef PRBS_CHK_BITCNT_EN
    , .bit_err_cnt(bc_a)
`endif
  );

  prbs_checker #(.LOCK_CNT(4), .LOSS_CNT(32), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_data(db), .clear(cb),
    .state(st_b), .locked(lk_b), .err_pulse(ep_b), .word_err_cnt(wc_b)
`ifdef PRBS_CHK_BITCNT_EN
    , .bit_err_cnt(bc_b)
`endif
  );

  function automatic logic [31:0] nx(input logic [31:0] w);
    return {w[30:0], w[31] ^ w[21] ^ w[1] ^ w[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic v, input logic [31:0] d, input logic c);
    @(negedge clk);
    va = v; da = d; ca = c;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic v, input logic [31:0] d, input logic c);
    @(negedge clk);
    vb = v; db = d; cb = c;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] gen;

  initial begin
    // reset state
    #12;
    chk("rst_state", 32'(st_a), 32'd0);
    chk("rst_locked", 32'(lk_a), 32'd0);
    chk("rst_err", 32'(ep_a), 32'd0);
    chk("rst_wcnt", 32'(wc_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // acquire on the published start of the sequence
    step_a(1'b1, 32'h00000001, 1'b0);
    chk("seed_state", 32'(st_a), 32'd1);
    step_a(1'b1, 32'h00000003, 1'b0);
    step_a(1'b1, 32'h00000006, 1'b0);
    step_a(1'b1, 32'h0000000D, 1'b0);
    chk("verify_state", 32'(st_a), 32'd1);
    chk("verify_unlocked", 32'(lk_a), 32'd0);
    step_a(1'b1, 32'h0000001B, 1'b0);
    chk("lock_state", 32'(st_a), 32'd2);
    chk("lock_locked", 32'(lk_a), 32'd1);
    chk("lock_wcnt", 32'(wc_a), 32'd0);
    gen = 32'h0000001B;

    // single 3-bit error
    gen = nx(gen);
    step_a(1'b1, gen ^ 32'h00000105, 1'b0);
    chk("err_pulse", 32'(ep_a), 32'd1);
    chk("err_wcnt", 32'(wc_a), 32'd1);
`ifdef PRBS_CHK_BITCNT_EN
    chk("err_bcnt", 32'(bc_a), 32'd3);
`endif
    gen = nx(gen);
    step_a(1'b1, gen, 1'b0);
    chk("clean_nopulse", 32'(ep_a), 32'd0);
    chk("clean_locked", 32'(lk_a), 32'd1);
    chk("clean_wcnt", 32'(wc_a), 32'd1);

    // idle cycle with clear only
    step_a(1'b0, 32'hDEADBEEF, 1'b1);
    chk("clear_wcnt", 32'(wc_a), 32'd0);
    chk("idle_nopulse", 32'(ep_a), 32'd0);
    chk("idle_locked", 32'(lk_a), 32'd1);

    // 8 consecutive corrupted words lose lock
    for (int i = 0; i < 8; i++) begin
      gen = nx(gen);
      step_a(1'b1, gen ^ 32'hFFFF0000, 1'b0);
      if (i == 6) chk("loss7_state", 32'(st_a), 32'd2);
    end
    chk("loss_state", 32'(st_a), 32'd0);
    chk("loss_locked", 32'(lk_a), 32'd0);
    chk("loss_pulse", 32'(ep_a), 32'd1);
    chk("loss_wcnt", 32'(wc_a), 32'd8);

    // relock after 5 clean words; counters persist
    for (int i = 0; i < 5; i++) begin
      gen = nx(gen);
      step_a(1'b1, gen, 1'b0);
      if (i == 0) chk("relock_seed", 32'(st_a), 32'd1);
      if (i == 3) chk("relock_pending", 32'(lk_a), 32'd0);
    end
    chk("relock_locked", 32'(lk_a), 32'd1);
    chk("relock_wcnt", 32'(wc_a), 32'd8);

    // asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(st_a), 32'd0);
    chk("arst_locked", 32'(lk_a), 32'd0);
    chk("arst_wcnt", 32'(wc_a), 32'd0);
`ifdef PRBS_CHK_BITCNT_EN
    chk("arst_bcnt", 32'(bc_a), 32'd0);
`endif
    va = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // zero words ignored in SEARCH; zero in VERIFY returns to SEARCH
    step_a(1'b1, 32'h00000000, 1'b0);
    step_a(1'b1, 32'h00000000, 1'b0);
    chk("zero_search", 32'(st_a), 32'd0);
    step_a(1'b1, 32'h00000005, 1'b0);
    chk("seed5_state", 32'(st_a), 32'd1);
    step_a(1'b1, 32'h00000000, 1'b0);
    chk("zero_verify", 32'(st_a), 32'd0);

    // bad word during VERIFY reseeds, full LOCK_CNT matches needed again
    step_a(1'b1, 32'h00001234, 1'b0);
    step_a(1'b1, nx(32'h00001234), 1'b0);
    step_a(1'b1, 32'h00000099, 1'b0);
    chk("reseed_state", 32'(st_a), 32'd1);
    gen = 32'h00000099;
    for (int i = 0; i < 4; i++) begin
      gen = nx(gen);
      step_a(1'b1, gen, 1'b0);
      if (i == 2) chk("reseed_pending", 32'(lk_a), 32'd0);
    end
    chk("reseed_locked", 32'(lk_a), 32'd1);
    chk("reseed_wcnt", 32'(wc_a), 32'd0);
    step_a(1'b0, 32'h0, 1'b0);

    // narrow counters saturate
    step_b(1'b1, 32'h00000001, 1'b0);
    step_b(1'b1, 32'h00000003, 1'b0);
    step_b(1'b1, 32'h00000006, 1'b0);
    step_b(1'b1, 32'h0000000D, 1'b0);
    step_b(1'b1, 32'h0000001B, 1'b0);
    chk("b_locked", 32'(lk_b), 32'd1);
    gen = 32'h0000001B;
    for (int i = 0; i < 20; i++) begin
      gen = nx(gen);
      step_b(1'b1, gen ^ 32'h0000000F, 1'b0);
      if (i == 0) begin
        chk("b_first_wcnt", 32'(wc_b), 32'd1);
`ifdef PRBS_CHK_BITCNT_EN
        chk("b_first_bcnt", 32'(bc_b), 32'd4);
`endif
      end
    end
    chk("b_sat_wcnt", 32'(wc_b), 32'd15);
`ifdef PRBS_CHK_BITCNT_EN
    chk("b_sat_bcnt", 32'(bc_b), 32'd15);
`endif
    chk("b_sat_state", 32'(st_b), 32'd2);

    // clear coincident with an error: clear wins, pulse still fires
    gen = nx(gen);
    step_b(1'b1, gen ^ 32'h00000001, 1'b1);
    chk("b_clr_wcnt", 32'(wc_b), 32'd0);
`ifdef PRBS_CHK_BITCNT_EN
    chk("b_clr_bcnt", 32'(bc_b), 32'd0);
`endif
    chk("b_clr_pulse", 32'(ep_b), 32'd1);
    gen = nx(gen);
    step_b(1'b1, gen, 1'b0);
    chk("b_clean_pulse", 32'(ep_b), 32'd0);
    chk("b_clean_wcnt", 32'(wc_b), 32'd0);
    chk("b_clean_locked", 32'(lk_b), 32'd1);
    step_b(1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Downstream consumer of the 32-bit LFSR pattern generator. Samples one generator word per valid strobe and self-synchronises by seeding an internal reference LFSR from the received data. Once locked, it flywheels the reference, flags mismatches and accumulates saturating error statistics. Sits between the generator output bus and the status/readout logic.

## Interface
- `LOCK_CNT`, 4: consecutive matching words required, after seeding, to enter LOCKED (≥1).
- `LOSS_CNT`, 8: consecutive mismatching words in LOCKED that force return to SEARCH (≥1).
- `CNT_W`, 16: width of the error counters.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` is a new generator word this cycle.
- `in_data`  in  32  generator word.
- `clear`  in  1  synchronous clear of both error counters.
- `state`  out  2  encoding: 0=SEARCH, 1=VERIFY, 2=LOCKED; 3 is never produced.
- `locked`  out  1  registered; high iff `state`==LOCKED.
- `err_pulse`  out  1  one-cycle pulse per counted word mismatch.
- `word_err_cnt`  out  CNT_W  mismatching words seen while LOCKED, saturating.
- `bit_err_cnt`  out  CNT_W  mismatching bits seen while LOCKED, saturating; present only with `PRBS_CHK_BITCNT_EN`.

## Operation
- Polynomial is x^32+x^22+x^2+x+1, one step per word: `next(w) = {w[30:0], w[31]^w[21]^w[1]^w[0]}`.
- Internal registers: `exp[31:0]`, `match_cnt`, `miss_cnt`, and the FSM state.
- Cycles with `in_valid`=0 change nothing except `clear` handling; `err_pulse` is low.
- **SEARCH**:
  - Valid non-zero word: `exp`←next(in_data), `match_cnt`←0, go to VERIFY.
  - Valid all-zero word (LFSR lock-up value): ignored, stay in SEARCH.
- **VERIFY**:
  - Valid word equal to `exp`: `exp`←next(exp), `match_cnt`+1. When the incremented value equals LOCK_CNT, go to LOCKED and set `miss_cnt`←0.
  - Mismatch, non-zero word: reseed (`exp`←next(in_data), `match_cnt`←0), stay in VERIFY.
  - Mismatch, all-zero word: go to SEARCH.
  - No counters change in this state.
- **LOCKED**:
  - Every valid word: `exp`←next(exp) (flywheel, never reseeded).
  - Match: `miss_cnt`←0.
  - Mismatch: `word_err_cnt`+1, `bit_err_cnt`+popcount(in_data^exp), `err_pulse`, `miss_cnt`+1. If `miss_cnt` reaches LOSS_CNT, go to SEARCH; the error on that word is still counted.
- Counters saturate at 2^CNT_W−1. The bit-count add clamps at the maximum and never wraps.
- `clear` zeroes both counters. If `clear` and a mismatch occur in the same cycle, `clear` wins and that error is not counted, but `err_pulse` still fires.
- Counters persist across loss of lock. Only reset and `clear` zero them.

## Timing
- Reset values: `state`=SEARCH, `locked`=0, `err_pulse`=0, both counters=0, `exp`=0, `match_cnt`=0, `miss_cnt`=0.
- Reset asserted mid-operation immediately returns every register to its reset value.
- All outputs are registered with 1-cycle latency from the sampling edge of the valid word.
- With back-to-back valid words, `locked` rises on the edge that samples word LOCK_CNT+1. The first word seeds; words 2..LOCK_CNT+1 match.
- `err_pulse` and the counter updates appear on the edge that samples the mismatching word.
- There is no backpressure: every valid word is accepted.

## Configuration
- `PRBS_CHK_BITCNT_EN` defined: `bit_err_cnt` port, popcount adder and counter are built.
- Not defined: the port is absent and there is no popcount logic. All other behaviour is identical.

## Test plan
- Reset, then feed 0x00000001, 0x00000003, 0x00000006, 0x0000000D, 0x0000001B on consecutive cycles -> `state` goes 0→1 after word 1; `locked`=1 after word 5; counters stay 0.
- Locked stream, next expected word replaced by expected^0x00000105 -> `err_pulse` for 1 cycle, `word_err_cnt`=1, `bit_err_cnt`=3. The following correct word gives no pulse and lock is held.
- Locked, then 8 consecutive corrupted words -> `word_err_cnt`=8, `state`=SEARCH after the 8th. Re-lock after 5 further clean words.
- All-zero words in SEARCH -> `state` stays 0. A bad word during VERIFY -> reseed, with `locked` delayed by the full LOCK_CNT.
- CNT_W=4, 20 corrupted words with LOSS_CNT=32 -> both counters hold 15. `clear` coincident with an error -> counters=0 and `err_pulse`=1.
- `rst_n` low while LOCKED with non-zero counters -> all outputs zero immediately (asynchronously); `state`=SEARCH.
